flow_hdr_builder: RTL and testbench

//  Match-action egress deparser; converse of the flow-key generator. Accepts a 128-bit flow key pulse
//  and emits the matching Ethernet/IPv4/UDP-or-TCP header as a 64-bit valid/ready byte stream.

---
 rtl/flow_hdr_pkg.sv | 56 +++++
 rtl/flow_hdr_builder_ipv4_csum.sv | 43 ++++
 rtl/flow_hdr_builder.sv | 177 +++++++++++++++++
 tb/tb_flow_hdr_builder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_hdr_pkg.sv
// Shared types and constants for the flow header builder.
// The IPV4_CSUM_EN macro enables the IPv4 header checksum pipeline.
package flow_hdr_pkg;

  typedef struct packed {
    logic [23:0] rsvd;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  proto;
  } flow_key_t;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  PROTO_UDP     = 8'd17;
  localparam logic [7:0]  PROTO_TCP     = 8'd6;

  localparam int ETH_HDR_LEN = 14;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;
  localparam int TCP_HDR_LEN = 20;

  // Longest header (TCP, 54 B) rounded up to whole 8-byte beats
  localparam int MAX_BEATS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CSUM0 = 2'd1,
    CSUM1 = 2'd2,
    SEND  = 2'd3
  } state_t;

  function automatic logic [15:0] l4_hdr_len(input logic [7:0] p);
    if (p == PROTO_TCP)      return 16'(TCP_HDR_LEN);
    else if (p == PROTO_UDP) return 16'(UDP_HDR_LEN);
    else                     return 16'd0;
  endfunction

  function automatic logic [5:0] hdr_bytes(input logic [7:0] p);
    return 6'(ETH_HDR_LEN + IP_HDR_LEN) + 6'(l4_hdr_len(p));
  endfunction

  function automatic logic [2:0] last_beat(input logic [7:0] p);
    logic [5:0] n;
    n = hdr_bytes(p) - 6'd1;
    return n[5:3];
  endfunction

  function automatic logic [7:0] last_keep(input logic [7:0] p);
    logic [5:0] n;
    n = hdr_bytes(p);
    if (n[2:0] == 3'd0) return 8'hFF;
    else                return 8'((9'd1 << n[2:0]) - 9'd1);
  endfunction

endpackage

// File: rtl/flow_hdr_builder_ipv4_csum.sv
// Two-stage IPv4 header checksum: wide sum of the ten header words, then
// end-around-carry fold and invert. Only instantiated with IPV4_CSUM_EN.
module ipv4_csum (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [9:0][15:0] words,
  output logic [15:0]     csum
);
  localparam int STAGES = 1;

  logic [STAGES:0] vld_pipe;
  logic [STAGES:1] vld_q;
  logic [19:0]     sum;
  logic [19:0]     acc;
  logic [16:0]     f1;
  logic [15:0]     f2;

  // Stage-valid shift chain; bit 0 is the live start strobe
  always_comb vld_pipe = {vld_q, start};

  // Sum of ten 16-bit words fits in 20 bits; fold twice to absorb every carry
  always_comb begin
    sum = '0;
    for (int i = 0; i < 10; i++) sum = sum + {4'd0, words[i]};
    f1 = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
    f2 = f1[15:0] + {15'd0, f1[16]};
  end

  // Accumulate in the first stage, fold and invert in the second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      acc   <= '0;
      csum  <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) acc  <= sum;
      if (vld_pipe[1]) csum <= ~f2;
    end
  end

endmodule

// File: rtl/flow_hdr_builder.sv
// Egress deparser: turns a flow key into an Ethernet/IPv4/(UDP|TCP) header
// streamed as 64-bit beats. Define IPV4_CSUM_EN to compute the IPv4
// checksum in-line (adds two cycles of latency); otherwise it is left 0.
module flow_hdr_builder
  import flow_hdr_pkg::*;
#(
  parameter int          DATA_WIDTH = 64,
  parameter logic [7:0]  IP_TTL     = 8'd64,
  parameter logic [7:0]  TCP_FLAGS  = 8'h18,
  parameter logic [15:0] TCP_WINDOW = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [127:0]            flow_key,
  input  logic                    valid_flow_key,
  output logic                    key_ready,
  input  logic [47:0]             src_mac,
  input  logic [47:0]             dst_mac,
  input  logic [15:0]             payload_len,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [15:0]             drop_cnt
);
  localparam int NB      = DATA_WIDTH / 8;
  localparam int PADW    = MAX_BEATS * DATA_WIDTH;
  localparam int HDR_W   = 8 * (ETH_HDR_LEN + IP_HDR_LEN + TCP_HDR_LEN);

  state_t    state;
  flow_key_t key_in;
  logic      unused_rsvd;

  logic [47:0] dmac_q, smac_q;
  logic [31:0] sip_q, dip_q;
  logic [15:0] sp_q, dp_q, plen_q, id_q, ip_id;
  logic [7:0]  proto_q;
  logic [2:0]  beat, nxt;

  logic [47:0] s_dmac, s_smac;
  logic [31:0] s_sip, s_dip;
  logic [15:0] s_sp, s_dp, s_plen, s_id;
  logic [7:0]  s_proto;
  logic [15:0] tot_len, udp_len, csum;
  logic [159:0] l4;
  logic [HDR_W-1:0] hdr;
  logic [PADW-1:0]  hdr_pad;
  logic [MAX_BEATS-1:0][DATA_WIDTH-1:0] beats;

  assign key_in      = flow_key;
  assign unused_rsvd = ^key_in.rsvd;
  assign key_ready   = (state == IDLE);
  assign nxt         = beat + 3'd1;

  // In IDLE the header is built from the live inputs so beat 0 can leave on
  // the accept edge; afterwards it comes from the latched copy.
  always_comb begin
    if (state == IDLE) begin
      s_dmac = dst_mac;         s_smac  = src_mac;
      s_sip  = key_in.src_ip;   s_dip   = key_in.dst_ip;
      s_sp   = key_in.src_port; s_dp    = key_in.dst_port;
      s_proto = key_in.proto;   s_plen  = payload_len;
      s_id   = ip_id;
    end else begin
      s_dmac = dmac_q;  s_smac  = smac_q;
      s_sip  = sip_q;   s_dip   = dip_q;
      s_sp   = sp_q;    s_dp    = dp_q;
      s_proto = proto_q; s_plen = plen_q;
      s_id   = id_q;
    end
  end

  // Header image in wire order (byte 0 in the MSBs), then sliced into beats
  always_comb begin
    tot_len = 16'(IP_HDR_LEN) + l4_hdr_len(s_proto) + s_plen;
    udp_len = 16'(UDP_HDR_LEN) + s_plen;
    if (s_proto == PROTO_TCP)
      l4 = {s_sp, s_dp, 32'h0, 32'h0, 8'h50, TCP_FLAGS, TCP_WINDOW, 16'h0, 16'h0};
    else if (s_proto == PROTO_UDP)
      l4 = {s_sp, s_dp, udp_len, 16'h0, 96'h0};
    else
      l4 = '0;
    hdr = {s_dmac, s_smac, ETH_TYPE_IPV4,
           8'h45, 8'h00, tot_len, s_id, 16'h4000, IP_TTL, s_proto, csum,
           s_sip, s_dip, l4};
    hdr_pad = {hdr, {(PADW-HDR_W){1'b0}}};
    beats = '0;
    for (int b = 0; b < MAX_BEATS; b++)
      for (int i = 0; i < NB; i++)
        beats[b][8*i +: 8] = hdr_pad[PADW-8-8*(b*NB+i) +: 8];
  end

`ifdef IPV4_CSUM_EN
  logic [9:0][15:0] csum_words;

  // Checksum covers the IPv4 header with its checksum field as zero
  always_comb csum_words = {16'h4500, tot_len, s_id, 16'h4000, IP_TTL, s_proto, 16'h0000,
                            s_sip[31:16], s_sip[15:0], s_dip[31:16], s_dip[15:0]};

  ipv4_csum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == CSUM0),
    .words (csum_words),
    .csum  (csum)
  );
`else
  assign csum = 16'h0000;
`endif

  // Main FSM: accept/drop keys, sequence beats, hold outputs while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      beat     <= '0;
      ip_id    <= '0;
      drop_cnt <= '0;
      dmac_q <= '0; smac_q <= '0; sip_q <= '0; dip_q <= '0;
      sp_q   <= '0; dp_q   <= '0; plen_q <= '0; id_q <= '0; proto_q <= '0;
    end else begin
      if (valid_flow_key && state != IDLE && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
      case (state)
        IDLE: if (valid_flow_key) begin
          dmac_q <= dst_mac;         smac_q  <= src_mac;
          sip_q  <= key_in.src_ip;   dip_q   <= key_in.dst_ip;
          sp_q   <= key_in.src_port; dp_q    <= key_in.dst_port;
          proto_q <= key_in.proto;   plen_q  <= payload_len;
          id_q   <= ip_id;
          ip_id  <= ip_id + 16'd1;
`ifdef IPV4_CSUM_EN
          state  <= CSUM0;
`else
          state    <= SEND;
          beat     <= '0;
          m_tvalid <= 1'b1;
          m_tlast  <= 1'b0;
          m_tkeep  <= '1;
          m_tdata  <= beats[0];
`endif
        end
`ifdef IPV4_CSUM_EN
        CSUM0: state <= CSUM1;
        CSUM1: begin
          state    <= SEND;
          beat     <= '0;
          m_tvalid <= 1'b1;
          m_tlast  <= 1'b0;
          m_tkeep  <= '1;
          m_tdata  <= beats[0];
        end
`endif
        SEND: if (m_tready) begin
          if (m_tlast) begin
            state    <= IDLE;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tkeep  <= '0;
            m_tdata  <= '0;
          end else begin
            beat    <= nxt;
            m_tdata <= beats[nxt];
            m_tlast <= (nxt == last_beat(proto_q));
            m_tkeep <= (nxt == last_beat(proto_q)) ? last_keep(proto_q) : '1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_hdr_builder.sv
// Self-checking bench for flow_hdr_builder: table of directed frames,
// hand-written stall/drop/reset sequences, then randomized frames with
// random backpressure compared against a byte-level header model.
module tb_flow_hdr_builder;
`ifdef IPV4_CSUM_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] flow_key = '0;
  logic         valid_flow_key = 1'b0;
  logic         key_ready;
  logic [47:0]  src_mac = '0, dst_mac = '0;
  logic [15:0]  payload_len = '0;
  logic [63:0]  m_tdata;
  logic [7:0]   m_tkeep;
  logic         m_tvalid, m_tlast;
  logic         m_tready = 1'b1;
  logic [15:0]  drop_cnt;

  flow_hdr_builder dut (
    .clk(clk), .rst_n(rst_n), .flow_key(flow_key), .valid_flow_key(valid_flow_key),
    .key_ready(key_ready), .src_mac(src_mac), .dst_mac(dst_mac), .payload_len(payload_len),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tready(m_tready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] m_id = '0;
  logic [15:0] m_drop = '0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          g_nb;
  logic [7:0]  g_keep;

  localparam logic [47:0] DM = 48'h001122334455;
  localparam logic [47:0] SM = 48'h66778899AABB;
  localparam logic [31:0] SIP = 32'hC0A80001;
  localparam logic [31:0] DIP = 32'hC0A80002;

  typedef struct {
    logic [7:0]  proto;
    logic [15:0] plen;
    int          mode;
    int          beats;
    logic [7:0]  keep;
    logic [15:0] tot;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_n(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) exp_q.push_back(v[8*k +: 8]);
  endtask

  // Reference header: fields laid out byte by byte from the protocol rules
  task automatic build_exp(input logic [47:0] dm, input logic [47:0] sm, input logic [31:0] si,
                           input logic [31:0] di, input logic [15:0] sp, input logic [15:0] dp,
                           input logic [7:0] pr, input logic [15:0] pl, input logic [15:0] id);
    int l4;
    logic [15:0] tot;
    int unsigned s;
    logic [15:0] c;
    exp_q.delete();
    l4  = (pr == 8'd17) ? 8 : (pr == 8'd6) ? 20 : 0;
    tot = 16'(20 + l4 + int'(pl));
    push_n(dm, 6); push_n(sm, 6); push_n(16'h0800, 2);
    push_n(8'h45, 1); push_n(8'h00, 1); push_n(tot, 2); push_n(id, 2);
    push_n(16'h4000, 2); push_n(8'd64, 1); push_n(pr, 1); push_n(16'h0, 2);
    push_n(si, 4); push_n(di, 4);
    if (pr == 8'd17) begin
      push_n(sp, 2); push_n(dp, 2); push_n(16'(8 + int'(pl)), 2); push_n(16'h0, 2);
    end else if (pr == 8'd6) begin
      push_n(sp, 2); push_n(dp, 2); push_n(32'h0, 4); push_n(32'h0, 4);
      push_n(8'h50, 1); push_n(8'h18, 1); push_n(16'hFFFF, 2); push_n(16'h0, 2); push_n(16'h0, 2);
    end
`ifdef IPV4_CSUM_EN
    s = 0;
    for (int i = 0; i < 10; i++) s += {16'h0, exp_q[14+2*i], exp_q[15+2*i]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    c = ~s[15:0];
    exp_q[24] = c[15:8];
    exp_q[25] = c[7:0];
`endif
  endtask

  // Send one key and collect its frame. mode 0: always ready, 1: 5-cycle
  // stall at beat 2, 2: random ready. inject pulses a key mid-frame.
  task automatic run_frame(input logic [47:0] dm, input logic [47:0] sm, input logic [31:0] si,
                           input logic [31:0] di, input logic [15:0] sp, input logic [15:0] dp,
                           input logic [7:0] pr, input logic [15:0] pl, input int mode, input bit inject);
    int cyc, nb, stall, expb, guard, rem;
    bit prev_stall, injected, done;
    logic [63:0] pd;
    logic [7:0] pk, lk;
    build_exp(dm, sm, si, di, sp, dp, pr, pl, m_id);
    m_id = m_id + 16'd1;
    expb = (exp_q.size() + 7) / 8;
    rem  = exp_q.size() % 8;
    lk   = (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
    got_q.delete();
    flow_key = {24'h0, si, di, sp, dp, pr};
    src_mac = sm; dst_mac = dm; payload_len = pl;
    valid_flow_key = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1;
    valid_flow_key = 1'b0;
    flow_key = {$urandom, $urandom, $urandom, $urandom};
    src_mac = {$urandom, $urandom}; dst_mac = {$urandom, $urandom}; payload_len = 16'($urandom);
    cyc = 1;
    while (!m_tvalid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("latency", cyc, LAT);
    nb = 0; stall = 0; prev_stall = 0; injected = 0; guard = 0; done = 0; g_keep = 8'h00;
    while (guard < 80 && !done) begin
      guard++;
      if (mode == 1 && nb == 2 && stall < 5) begin m_tready = 1'b0; stall++; end
      else if (mode == 2) m_tready = ($urandom_range(0, 2) != 0);
      else m_tready = 1'b1;
      if (inject && nb == 2 && !injected) begin
        valid_flow_key = 1'b1; flow_key = {$urandom, $urandom, $urandom, $urandom};
        injected = 1; m_drop = m_drop + 16'd1;
      end else valid_flow_key = 1'b0;
      if (prev_stall) begin
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_tdata", m_tdata, pd);
        chk("stall_tkeep", m_tkeep, pk);
      end
      if (!m_tvalid) begin chk("tvalid_midframe", m_tvalid, 1); break; end
      prev_stall = !m_tready; pd = m_tdata; pk = m_tkeep;
      if (m_tready) begin
        chk($sformatf("tlast_beat%0d", nb), m_tlast, nb == expb - 1);
        chk($sformatf("tkeep_beat%0d", nb), m_tkeep, (nb == expb - 1) ? lk : 8'hFF);
        for (int i = 0; i < 8; i++) if (m_tkeep[i]) got_q.push_back(m_tdata[8*i +: 8]);
        g_keep = m_tkeep;
        nb++;
        if (m_tlast) done = 1;
      end
      if (!done) begin @(posedge clk); #1; end
    end
    if (!done) chk("frame_timeout", 0, 1);
    g_nb = nb;
    chk("beats", nb, expb);
    valid_flow_key = 1'b0; m_tready = 1'b1;
    @(posedge clk); #1;
    chk("bubble_tvalid", m_tvalid, 0);
    chk("idle_key_ready", key_ready, 1);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("frame_len", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("frame_byte%0d", i), got_q[i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] pr;
    int cyc;
    tbl[0] = '{8'd17, 16'd18,    0, 6, 8'h03, 16'h002E};
    tbl[1] = '{8'd6,  16'd18,    0, 7, 8'h3F, 16'h003A};
    tbl[2] = '{8'd1,  16'd18,    0, 5, 8'h03, 16'h0026};
    tbl[3] = '{8'd17, 16'd18,    1, 6, 8'h03, 16'h002E};
    tbl[4] = '{8'd17, 16'hFFF0,  0, 6, 8'h03, 16'h000C};
    tbl[5] = '{8'd6,  16'hFFFF,  2, 7, 8'h3F, 16'h0027};

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tkeep", m_tkeep, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_key_ready", key_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int t = 0; t < 6; t++) begin
      run_frame(DM, SM, SIP, DIP, 16'h04D2, 16'h0050, tbl[t].proto, tbl[t].plen, tbl[t].mode, 1'b0);
      chk($sformatf("tbl%0d_beats", t), g_nb, tbl[t].beats);
      chk($sformatf("tbl%0d_last_keep", t), g_keep, tbl[t].keep);
      if (got_q.size() > 17) chk($sformatf("tbl%0d_total_len", t), {got_q[16], got_q[17]}, tbl[t].tot);
      if (t == 0 && got_q.size() > 39) begin
`ifdef IPV4_CSUM_EN
        chk("udp_csum", {got_q[24], got_q[25]}, 16'hB96B);
`else
        chk("udp_csum", {got_q[24], got_q[25]}, 16'h0000);
`endif
        chk("udp_len", {got_q[38], got_q[39]}, 16'h001A);
      end
      if (t == 1 && got_q.size() > 47) begin
        chk("tcp_byte46", got_q[46], 8'h50);
        chk("tcp_byte47", got_q[47], 8'h18);
      end
      if (t == 2) chk("other_size", got_q.size(), 34);
    end

    // Reset in the middle of a frame, while beat 3 is presented
    flow_key = {24'h0, SIP, DIP, 16'h04D2, 16'h0050, 8'd17};
    src_mac = SM; dst_mac = DM; payload_len = 16'd18; valid_flow_key = 1'b1;
    @(posedge clk); #1;
    valid_flow_key = 1'b0;
    cyc = 1;
    while (!m_tvalid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_pre_tvalid", m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_tlast", m_tlast, 0);
    chk("midrst_tdata", m_tdata, 0);
    chk("midrst_key_ready", key_ready, 1);
    chk("midrst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; m_id = '0; m_drop = '0;
    @(posedge clk); #1;

    // Key arriving mid-frame is dropped; frame and ip_id sequence unaffected
    run_frame(DM, SM, SIP, DIP, 16'h04D2, 16'h0050, 8'd17, 16'd18, 0, 1'b1);
    if (got_q.size() > 19) chk("postrst_ip_id", {got_q[18], got_q[19]}, 16'h0000);
    chk("drop_one", drop_cnt, 16'd1);
    run_frame(DM, SM, SIP, DIP, 16'h04D2, 16'h0050, 8'd6, 16'd100, 0, 1'b0);
    if (got_q.size() > 19) chk("next_ip_id", {got_q[18], got_q[19]}, 16'h0001);

    // Randomized frames with random backpressure and occasional drops
    for (int r = 0; r < 24; r++) begin
      case ($urandom_range(0, 3))
        0: pr = 8'd17;
        1: pr = 8'd6;
        default: pr = 8'($urandom);
      endcase
      run_frame({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom,
                16'($urandom), 16'($urandom), pr, 16'($urandom), 2, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
